// File: rtl/sfp_port_ctrl_pkg.sv
// Shared types and constants for the SFP port sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfp_ctrl_pkg;

  // Counter width sized to hold the largest timing parameter (30M cycles).
  localparam int CNT_W = 25;

  // Synchronizer reset values: treat the cage as empty, dark and fault-free.
  localparam logic DETECT_N_RST = 1'b1;
  localparam logic LOS_RST      = 1'b1;
  localparam logic FAULT_RST    = 1'b0;

  typedef enum logic [2:0] {
    ST_ABSENT     = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_IDLE       = 3'd2,
    ST_INIT       = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT_HOLD = 3'd5,
    ST_FAILED     = 3'd6
  } state_t;

  // Retry counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sfp_port_ctrl_if.sv
// Cage pins, user enable and status outputs of one SFP port.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels.
interface sfp_port_ctrl_if;
  logic       enable;
  logic       detect_n;
  logic       los;
  logic       fault;
  logic       tx_disable;
  logic       present;
  logic       tx_active;
  logic       link_up;
  logic       fault_latched;
  logic [3:0] retry_count;
  logic [2:0] state;

  // Board/cage side: drives pins and enable, observes controller status.
  modport master (
    output enable, detect_n, los, fault,
    input  tx_disable, present, tx_active, link_up, fault_latched, retry_count, state
  );

  // Controller side.
  modport slave (
    input  enable, detect_n, los, fault,
    output tx_disable, present, tx_active, link_up, fault_latched, retry_count, state
  );
endinterface

// File: rtl/sfp_port_ctrl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 cycles from pin to q.
// Backpressure: none.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage capture; reset loads the safe idle level into both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sfp_port_ctrl.sv
// SFP port sequencer: insertion debounce, t_init bring-up, TX_FAULT retry, LOS-qualified link.
// Latency: 3 cycles pin-to-state (2 sync + 1 FSM); enable acts on the next edge; outputs registered.
// Backpressure: none; level-driven, tx_disable is high in every state except INIT and RUN.
module sfp_port_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned INIT_CYCLES       = 30_000_000,
  parameter int unsigned FAULT_HOLD_CYCLES = 1_000,
  parameter int unsigned MAX_RETRIES       = 3,
  parameter int unsigned LOS_CYCLES        = 100_000
) (
  input  logic          clk,
  input  logic          rst,
  sfp_port_ctrl_if.slave sif
);
  import sfp_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOS_LAST  = CNT_W'(LOS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic det_n_s, los_s, fault_s;

  sync_2ff #(.RST_VAL(DETECT_N_RST)) u_sync_det   (.clk(clk), .rst(rst), .d(sif.detect_n), .q(det_n_s));
  sync_2ff #(.RST_VAL(LOS_RST))      u_sync_los   (.clk(clk), .rst(rst), .d(sif.los),      .q(los_s));
  sync_2ff #(.RST_VAL(FAULT_RST))    u_sync_fault (.clk(clk), .rst(rst), .d(sif.fault),    .q(fault_s));

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] los_cnt_q, los_cnt_nxt;
  logic [3:0]       retry_q, retry_nxt;
  logic             tx_disable_q, present_q, tx_active_q, link_up_q, fault_latched_q;
  logic             tx_disable_nxt, present_nxt, tx_active_nxt, link_up_nxt, fault_latched_nxt;

  // State, counters and registered outputs; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_ABSENT;
      cnt_q           <= '0;
      los_cnt_q       <= '0;
      retry_q         <= '0;
      tx_disable_q    <= 1'b1;
      present_q       <= 1'b0;
      tx_active_q     <= 1'b0;
      link_up_q       <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      cnt_q           <= cnt_nxt;
      los_cnt_q       <= los_cnt_nxt;
      retry_q         <= retry_nxt;
      tx_disable_q    <= tx_disable_nxt;
      present_q       <= present_nxt;
      tx_active_q     <= tx_active_nxt;
      link_up_q       <= link_up_nxt;
      fault_latched_q <= fault_latched_nxt;
    end
  end

  // Next state: removal beats enable=0 beats fault beats timer expiry.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    retry_nxt = retry_q;
    case (state_q)
      ST_ABSENT: begin
        if (!det_n_s) begin
          state_nxt = ST_DEBOUNCE;
          cnt_nxt   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (det_n_s) begin
          state_nxt = ST_ABSENT;
          cnt_nxt   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_nxt = sif.enable ? ST_INIT : ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      default: begin
        if (det_n_s) begin
          state_nxt = ST_ABSENT;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else if (!sif.enable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              state_nxt = ST_INIT;
              cnt_nxt   = '0;
            end
            ST_INIT: begin
              // Fault is only looked at once t_init has elapsed.
              if (cnt_q == INIT_LAST) begin
                state_nxt = fault_s ? ST_FAULT_HOLD : ST_RUN;
                retry_nxt = fault_s ? sat_inc4(retry_q) : retry_q;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_q + CNT_ONE;
              end
            end
            ST_RUN: begin
              if (fault_s) begin
                state_nxt = ST_FAULT_HOLD;
                retry_nxt = sat_inc4(retry_q);
                cnt_nxt   = '0;
              end else if (cnt_q == INIT_LAST) begin
                retry_nxt = '0;
              end else begin
                cnt_nxt = cnt_q + CNT_ONE;
              end
            end
            ST_FAULT_HOLD: begin
              if (cnt_q == HOLD_LAST) begin
                state_nxt = (retry_q <= RETRY_MAX) ? ST_INIT : ST_FAILED;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_q + CNT_ONE;
              end
            end
            ST_FAILED: state_nxt = ST_FAILED;
            default:   state_nxt = ST_ABSENT;
          endcase
        end
      end
    endcase
  end

  // Outputs decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    tx_disable_nxt    = !((state_nxt == ST_INIT) || (state_nxt == ST_RUN));
    tx_active_nxt     = (state_nxt == ST_RUN);
    present_nxt       = !((state_nxt == ST_ABSENT) || (state_nxt == ST_DEBOUNCE));
    fault_latched_nxt = (state_nxt == ST_FAILED);
    los_cnt_nxt       = los_cnt_q;
    link_up_nxt       = link_up_q;
    // LOS qualification runs only while staying in RUN; any los=1 restarts it.
    if (!((state_q == ST_RUN) && (state_nxt == ST_RUN)) || los_s) begin
      los_cnt_nxt = '0;
      link_up_nxt = 1'b0;
    end else if (los_cnt_q == LOS_LAST) begin
      link_up_nxt = 1'b1;
    end else begin
      los_cnt_nxt = los_cnt_q + CNT_ONE;
    end
  end

  assign sif.tx_disable    = tx_disable_q;
  assign sif.present       = present_q;
  assign sif.tx_active     = tx_active_q;
  assign sif.link_up       = link_up_q;
  assign sif.fault_latched = fault_latched_q;
  assign sif.retry_count   = retry_q;
  assign sif.state         = state_q;

endmodule

// File: tb/tb_sfp_port_ctrl.sv
// Directed bench for sfp_port_ctrl with shortened timing parameters.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: n/a.
module tb_sfp_port_ctrl;
  import sfp_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  sfp_port_ctrl_if sif();

  sfp_port_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .INIT_CYCLES      (8),
    .FAULT_HOLD_CYCLES(5),
    .MAX_RETRIES      (2),
    .LOS_CYCLES       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       en, dn, l, f;
    logic [2:0] st;
    logic       txd, pres, act, link, flat;
    logic [3:0] rc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int n, logic en, logic dn, logic l, logic f, logic [2:0] st,
                              logic txd, logic pres, logic act, logic link, logic flat,
                              logic [3:0] rc);
    vec_t v;
    v = '{n, en, dn, l, f, st, txd, pres, act, link, flat, rc};
    return v;
  endfunction

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [2:0] st, logic txd, logic pres, logic act,
                         logic link, logic flat, logic [3:0] rc);
    chk({tag, ".state"},         32'(sif.state),         32'(st));
    chk({tag, ".tx_disable"},    32'(sif.tx_disable),    32'(txd));
    chk({tag, ".present"},       32'(sif.present),       32'(pres));
    chk({tag, ".tx_active"},     32'(sif.tx_active),     32'(act));
    chk({tag, ".link_up"},       32'(sif.link_up),       32'(link));
    chk({tag, ".fault_latched"}, 32'(sif.fault_latched), 32'(flat));
    chk({tag, ".retry_count"},   32'(sif.retry_count),   32'(rc));
  endtask

  initial begin
    // en dn los f | state txd pres act link flat retry
    // Fault held in RUN: three holds, then FAILED; enable=0 recovers to IDLE.
    vq.push_back(mk(2, 1, 0, 0, 1, ST_RUN,        0, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 1));
    vq.push_back(mk(4, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 1, ST_INIT,       0, 1, 0, 0, 0, 1));
    vq.push_back(mk(7, 1, 0, 0, 1, ST_INIT,       0, 1, 0, 0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 2));
    vq.push_back(mk(5, 1, 0, 0, 1, ST_INIT,       0, 1, 0, 0, 0, 2));
    vq.push_back(mk(8, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 3));
    vq.push_back(mk(4, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 3));
    vq.push_back(mk(1, 1, 0, 0, 1, ST_FAILED,     1, 1, 0, 0, 1, 3));
    vq.push_back(mk(3, 1, 0, 0, 1, ST_FAILED,     1, 1, 0, 0, 1, 3));
    vq.push_back(mk(1, 0, 0, 0, 1, ST_IDLE,       1, 1, 0, 0, 0, 0));
    // Fault pulse in the middle of INIT is ignored.
    vq.push_back(mk(3, 0, 0, 0, 0, ST_IDLE,       1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(2, 1, 0, 0, 1, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(4, 1, 0, 0, 0, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 0, 0, 0));
    // One recovered fault, then a fault-free RUN stretch clears retry_count.
    vq.push_back(mk(3, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 1));
    vq.push_back(mk(5, 1, 0, 0, 0, ST_INIT,       0, 1, 0, 0, 0, 1));
    vq.push_back(mk(8, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 0, 0, 1));
    vq.push_back(mk(3, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 1, 0, 1));
    vq.push_back(mk(4, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 1, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 1, 0, 0));
    // Removal mid-RUN.
    vq.push_back(mk(2, 1, 1, 0, 0, ST_RUN,        0, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, ST_ABSENT,     1, 0, 0, 0, 0, 0));
    // Re-insert with enable high, then fault and enable=0 land on the same edge.
    vq.push_back(mk(6, 1, 0, 0, 0, ST_DEBOUNCE,   1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(8, 1, 0, 0, 0, ST_RUN,        0, 1, 1, 0, 0, 0));
    vq.push_back(mk(2, 1, 0, 0, 1, ST_RUN,        0, 1, 1, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, ST_IDLE,       1, 1, 0, 0, 0, 0));
    // Fault present at t_init expiry, leaving the port in FAULT_HOLD for the reset test.
    vq.push_back(mk(8, 1, 0, 0, 1, ST_INIT,       0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 1));
    vq.push_back(mk(2, 1, 0, 0, 1, ST_FAULT_HOLD, 1, 1, 0, 0, 0, 1));

    // Reset state.
    rst = 1'b1;
    sif.enable = 1'b0; sif.detect_n = 1'b1; sif.los = 1'b1; sif.fault = 1'b0;
    tick(3);
    chk_all("reset", ST_ABSENT, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    sif.los = 1'b0;
    tick(2);
    chk("absent_idle.state", 32'(sif.state), 32'(ST_ABSENT));

    // Insertion bounce: low 2, high 1, then low; present 7 edges after the final fall.
    sif.detect_n = 1'b0; tick(2);
    sif.detect_n = 1'b1; tick(1);
    sif.detect_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk($sformatf("bounce.present[%0d]", i), 32'(sif.present), 32'(i == 7));
      if (i == 2) chk("bounce.back_absent", 32'(sif.state), 32'(ST_ABSENT));
      if (i == 3) chk("bounce.redebounce", 32'(sif.state), 32'(ST_DEBOUNCE));
    end
    chk("bounce.idle", 32'(sif.state), 32'(ST_IDLE));
    sif.enable = 1'b1;
    tick(1);
    chk("enable.state", 32'(sif.state), 32'(ST_INIT));
    chk("enable.tx_disable", 32'(sif.tx_disable), 32'd0);

    // Clean bring-up: 8 cycles of INIT with the laser on, then RUN and link qualification.
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk($sformatf("init.state[%0d]", i), 32'(sif.state), 32'(i == 8 ? ST_RUN : ST_INIT));
      chk($sformatf("init.tx_disable[%0d]", i), 32'(sif.tx_disable), 32'd0);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("link.qual[%0d]", i), 32'(sif.link_up), 32'(i == 3));
    end
    // One-cycle LOS glitch drops the link, which re-qualifies 3 cycles later.
    sif.los = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      sif.los = 1'b0;
      chk($sformatf("los_pulse.link[%0d]", k), 32'(sif.link_up), 32'((k <= 2) || (k == 6)));
    end

    foreach (vq[i]) begin
      sif.enable = vq[i].en; sif.detect_n = vq[i].dn; sif.los = vq[i].l; sif.fault = vq[i].f;
      tick(vq[i].n);
      chk_all($sformatf("v%0d", i), vq[i].st, vq[i].txd, vq[i].pres, vq[i].act,
              vq[i].link, vq[i].flat, vq[i].rc);
    end

    // Reset in the middle of FAULT_HOLD returns everything to reset values on the next edge.
    rst = 1'b1;
    tick(1);
    chk_all("rst_mid_hold", ST_ABSENT, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
